// File: rtl/fsml_arb_pkg.sv
// Shared definitions for the stream arbiter: frame-sequencer state encoding
// and the hit-count saturation helper.
package fsml_arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        STREAM = ST_STREAM,
        DRAIN  = ST_DRAIN,
        DONE   = ST_DONE
    } arb_state_e;

    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/fsml_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping,
// returned both as a one-hot grant and as an index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        // Offset 1 first, so the current pointer holder is considered last.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fsml_stream_arbiter.sv
// Time-shares one serial sequence detector among N_REQ bit-stream sources,
// one fixed-length frame per grant, and reports hits per frame and owner.
module fsml_stream_arbiter
    import fsml_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ-1:0]           Din_bus,
    output logic [N_REQ-1:0]           Grant,
    output logic                       Busy,
    output logic                       Det_Reset_n,
    output logic                       Det_Din,
    input  logic                       Det_Dout,
    output logic                       Frame_Done,
    output logic [CNT_W-1:0]           Hit_Count,
    output logic [$clog2(N_REQ)-1:0]   Hit_Owner
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [BW-1:0]    LAST_BIT = BW'(FRAME_LEN - 1);
    localparam logic [OW-1:0]    PTR_INIT = OW'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(unsigned'(CNT_W)));

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [OW-1:0]    hit_own_q, hit_own_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [OW-1:0]    pick_idx;
    logic             pick_any;
    logic             hit_smp;
    logic [CNT_W-1:0] acc_inc;

    rr_pick #(.N(N_REQ), .IW(OW)) u_pick (
        .req_i (Req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign Grant       = grant_q;
    assign Busy        = (state_q != IDLE);
    assign Frame_Done  = (state_q == DONE);
    assign Det_Reset_n = (state_q == STREAM) || (state_q == DRAIN);
    assign Det_Din     = (state_q == STREAM) && Din_bus[owner_q];
    assign Hit_Count   = hit_cnt_q;
    assign Hit_Owner   = hit_own_q;

    // The detector's Moore output lags its input by one edge, so the first
    // STREAM cycle carries no result and DRAIN carries the last bit's.
    assign hit_smp = Det_Dout && (((state_q == STREAM) && (bitcnt_q != '0)) ||
                                  (state_q == DRAIN));
    assign acc_inc = (hit_smp && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        bitcnt_d  = bitcnt_q;
        acc_d     = acc_q;
        hit_cnt_d = hit_cnt_q;
        hit_own_d = hit_own_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bitcnt_d = '0;
                acc_d    = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                bitcnt_d = bitcnt_q + 1'b1;
                acc_d    = acc_inc;
                if (bitcnt_q == LAST_BIT) state_d = DRAIN;
            end
            DRAIN: begin
                // Results are loaded on entry to DONE so they are valid
                // alongside the Frame_Done pulse.
                acc_d     = acc_inc;
                hit_cnt_d = acc_inc;
                hit_own_d = owner_q;
                ptr_d     = owner_q;
                grant_d   = '0;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= PTR_INIT;
            bitcnt_q  <= '0;
            acc_q     <= '0;
            hit_cnt_q <= '0;
            hit_own_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            bitcnt_q  <= bitcnt_d;
            acc_q     <= acc_d;
            hit_cnt_q <= hit_cnt_d;
            hit_own_q <= hit_own_d;
        end
    end

endmodule

// File: tb/tb_fsml_stream_arbiter.sv
// Bench for fsml_stream_arbiter: a registered stub detector (Dout <= Din) makes
// the expected hit count the number of ones streamed by the frame owner.
module tb_fsml_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Req, Din_bus, Grant;
    logic       Busy, Det_Reset_n, Det_Din, Det_Dout, Frame_Done;
    logic [3:0] Hit_Count;
    logic [1:0] Hit_Owner;

    logic [3:0] req2, din2, grant2;
    logic       busy2, drst2, ddin2, ddout2, fd2;
    logic [1:0] hc2;
    logic [1:0] ho2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int owner;
        int hits;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [3:0] req;
        logic [7:0] pat;
        int         owner;
        int         hits;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    fsml_stream_arbiter #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(4)) u_dut (
        .Clock(clk), .Reset(rst), .Req(Req), .Din_bus(Din_bus), .Grant(Grant),
        .Busy(Busy), .Det_Reset_n(Det_Reset_n), .Det_Din(Det_Din), .Det_Dout(Det_Dout),
        .Frame_Done(Frame_Done), .Hit_Count(Hit_Count), .Hit_Owner(Hit_Owner)
    );

    fsml_stream_arbiter #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(2)) u_sat (
        .Clock(clk), .Reset(rst), .Req(req2), .Din_bus(din2), .Grant(grant2),
        .Busy(busy2), .Det_Reset_n(drst2), .Det_Din(ddin2), .Det_Dout(ddout2),
        .Frame_Done(fd2), .Hit_Count(hc2), .Hit_Owner(ho2)
    );

    // Stub detectors
    always_ff @(posedge clk) begin
        if (!Det_Reset_n) Det_Dout <= 1'b0;
        else              Det_Dout <= Det_Din;
        if (!drst2) ddout2 <= 1'b0;
        else        ddout2 <= ddin2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor and one-hot grant check
    always @(negedge clk) begin
        if (!rst && Frame_Done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("hit_owner", 32'(Hit_Owner), e.owner);
                chk("hit_count", 32'(Hit_Count), e.hits);
            end
        end
        if (Grant != '0) chk("grant_onehot", 32'($onehot(Grant)), 1);
    end

    task automatic wait_idle();
        int n = 0;
        while ((Busy || sbq.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 32'(n < 40), 1);
    endtask

    task automatic do_frame(input logic [3:0] req, input logic [7:0] pat,
                            input int owner, input int hits);
        int n = 0;
        @(negedge clk);
        Req     = req;
        Din_bus = '0;
        sbq.push_back('{owner, hits});
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (Grant == '0 && n < 40);
        chk("grant", 32'(Grant), 32'(1) << owner);
        chk("busy", 32'(Busy), 1);
        Req = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < 4; r++)
                Din_bus[r] = (r == owner) ? pat[7-k] : ~pat[7-k];
        end
        @(posedge clk);
        #1;
        Din_bus = '0;
        wait_idle();
    endtask

    initial begin
        logic [7:0] pat;
        int n, t, prev, got, fd_seen;

        vecs[0] = '{4'b0100, 8'b10110010, 2, 4};
        vecs[1] = '{4'b1111, 8'b11111111, 3, 8};
        vecs[2] = '{4'b1111, 8'b00000000, 0, 0};
        vecs[3] = '{4'b1111, 8'b10000001, 1, 2};
        vecs[4] = '{4'b1010, 8'b01010101, 3, 4};
        vecs[5] = '{4'b1010, 8'b11100000, 1, 3};
        vecs[6] = '{4'b0001, 8'b00000001, 0, 1};
        vecs[7] = '{4'b1000, 8'b10000000, 3, 1};

        rst = 1'b1; Req = '0; Din_bus = '0; req2 = '0; din2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_det_reset_n", 32'(Det_Reset_n), 0);
        chk("rst_det_din", 32'(Det_Din), 0);
        chk("rst_frame_done", 32'(Frame_Done), 0);
        chk("rst_hit_count", 32'(Hit_Count), 0);
        chk("rst_hit_owner", 32'(Hit_Owner), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            do_frame(vecs[v].req, vecs[v].pat, vecs[v].owner, vecs[v].hits);

        // Single requester, cycle-exact timing from the granting edge
        pat = 8'b10110010;
        @(negedge clk);
        Req = 4'b0100;
        sbq.push_back('{2, 4});
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            Req = '0;
            Din_bus = '0;
            if (c >= 2 && c <= 9) Din_bus[2] = pat[9-c];
            #1;
            chk("timing_grant", 32'(Grant), (c <= 10) ? 32'h4 : 32'h0);
            chk("timing_frame_done", 32'(Frame_Done), 32'(c == 11));
            chk("timing_det_reset_n", 32'(Det_Reset_n), 32'(c >= 2 && c <= 10));
            chk("timing_det_din", 32'(Det_Din), (c >= 2 && c <= 9) ? 32'(pat[9-c]) : 32'h0);
        end
        Din_bus = '0;
        wait_idle();

        // Req[1] dropped during STREAM cycle 3
        @(negedge clk);
        Req = 4'b0010;
        Din_bus = 4'b0010;
        sbq.push_back('{1, 8});
        n = 0;
        do begin @(posedge clk); #1; n++; end while (Grant == '0 && n < 40);
        chk("drop_grant", 32'(Grant), 32'h2);
        repeat (3) begin @(posedge clk); #1; end
        Req = '0;
        wait_idle();
        Din_bus = '0;

        // Reset asserted during STREAM cycle 4
        @(negedge clk);
        Req = 4'b0001;
        Din_bus = 4'b0001;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (Grant == '0 && n < 40);
        chk("rst_mid_grant_before", 32'(Grant), 32'h1);
        Req = '0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_grant", 32'(Grant), 0);
        chk("rst_mid_det_reset_n", 32'(Det_Reset_n), 0);
        chk("rst_mid_hit_count", 32'(Hit_Count), 0);
        chk("rst_mid_frame_done", 32'(Frame_Done), 0);
        chk("rst_mid_busy", 32'(Busy), 0);
        Din_bus = '0;
        fd_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (Frame_Done) fd_seen++;
        end
        chk("rst_mid_no_frame_done", 32'(fd_seen), 0);
        do_frame(4'b1000, 8'b11001100, 3, 4);

        // All requests high: rotation and frame spacing
        @(negedge clk);
        Req = 4'b1111;
        Din_bus = '0;
        for (int k = 0; k < 5; k++) sbq.push_back('{k % 4, 0});
        t = 0; prev = 0; got = 0;
        while (got < 5 && t < 100) begin
            @(negedge clk);
            t++;
            if (Frame_Done) begin
                if (got > 0) chk("frame_spacing", 32'(t - prev), 12);
                prev = t;
                got++;
                if (got == 5) Req = '0;
            end
        end
        chk("rotation_frames", 32'(got), 5);
        wait_idle();

        // Saturation with a 2-bit hit counter
        @(negedge clk);
        req2 = 4'b0001;
        din2 = 4'b0001;
        n = 0;
        while (!fd2 && n < 40) begin
            @(negedge clk);
            if (grant2 != '0) req2 = '0;
            n++;
        end
        chk("sat_frame_done", 32'(fd2), 1);
        chk("sat_hit_count", 32'(hc2), 3);
        chk("sat_hit_owner", 32'(ho2), 0);
        din2 = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsml_stream_arbiter.md
# fsml_stream_arbiter

Round-robin scheduler that shares one serial sequence-detector FSM (`fsml_behavioral`-class block: `Dout, Clock, Reset, Din`) among several serial bit-stream requesters. It grants the detector to one requester per frame, clears the detector before each frame, and steers that requester's bit stream into it for a fixed frame length. It then counts the detector's `Dout` hits and reports the per-frame hit count and owner. It sits between the stream sources and the single shared detector instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `FRAME_LEN`, 8: bits streamed per grant (≥2).
- `CNT_W`, 4: hit-count width.
- `Clock` in 1: single clock, all state updates on rising edge.
- `Reset` in 1: synchronous, active-high; overrides everything.
- `Req` in N_REQ: per-requester request, level-sensitive.
- `Din_bus` in N_REQ: per-requester serial data bit.
- `Grant` out N_REQ: one-hot grant, registered.
- `Busy` out 1: high whenever state ≠ IDLE.
- `Det_Reset_n` out 1: drives the detector's `Reset` port; active-low.
- `Det_Din` out 1: drives the detector's `Din`.
- `Det_Dout` in 1: detector's Moore output.
- `Frame_Done` out 1: one-cycle pulse at end of frame.
- `Hit_Count` out CNT_W: hits in last completed frame; held until next `Frame_Done`.
- `Hit_Owner` out clog2(N_REQ): index of last completed frame's owner; held with `Hit_Count`.

## Operation
- Reset values:
  - `Grant` = 0, `Busy` = 0, `Det_Reset_n` = 0, `Det_Din` = 0.
  - `Frame_Done` = 0, `Hit_Count` = 0, `Hit_Owner` = 0.
  - State = IDLE, rr pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- IDLE:
  - `Det_Reset_n` = 0.
  - If any `Req` is high, pick the first set bit searching from pointer+1, wrapping.
  - Load `Grant` (one-hot) and owner, go to CLEAR. Otherwise stay.
- CLEAR:
  - One cycle; `Det_Reset_n` = 0.
  - Bit counter ← 0, hit accumulator ← 0.
  - Go to STREAM.
- STREAM:
  - `Det_Reset_n` = 1.
  - `Det_Din` = `Din_bus[owner]`, combinational pass-through.
  - Bit counter increments every cycle.
  - After FRAME_LEN cycles (counter = FRAME_LEN-1), go to DRAIN.
- DRAIN:
  - One cycle; `Det_Reset_n` = 1, `Det_Din` = 0.
  - Captures the detector's output for the last bit.
- Hit sampling:
  - Accumulator increments on `Det_Dout` = 1 at the edges ending STREAM cycles 2..FRAME_LEN and the DRAIN cycle (FRAME_LEN samples).
  - Saturates at 2^CNT_W-1.
- DONE:
  - `Frame_Done` = 1, `Grant` = 0.
  - `Hit_Count` ← accumulator, `Hit_Owner` ← owner, pointer ← owner.
  - Next state IDLE.
- `Det_Din` is forced to 0 in every state other than STREAM.
- `Req` is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- `Reset` mid-frame: all outputs and state return to reset values at that edge. The detector is held in reset (`Det_Reset_n` = 0) from the next cycle.

## Timing
- `Req` high before edge e0 while in IDLE → `Grant` and CLEAR visible after e0.
- STREAM occupies cycles e1..e(FRAME_LEN); DRAIN follows; `Frame_Done` is high in the cycle after edge e(FRAME_LEN+2).
- Minimum frame period is FRAME_LEN+4 cycles: a requester holding `Req` continuously regains access no earlier than one IDLE cycle after DONE.
- With all `Req` high, grants rotate 0,1,2,…,N_REQ-1,0.
- `Busy` and `Grant` change only on clock edges. `Det_Din` and `Det_Reset_n` are combinational from state and owner registers.

## Structure
- Package `fsml_arb_pkg` holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, DONE);
  - localparams for the state encoding;
  - the saturation-max helper for CNT_W.
- Sub-module `rr_pick`: combinational round-robin picker (`Req`, pointer → one-hot grant + index), reused by other arbiters.

## Test plan
- Stub detector for the bench: `Dout <= Din` registered, reset when `Det_Reset_n` = 0. With it, hits equal the number of ones in the frame.
- Single requester: `Req[2]` = 1, `Din_bus[2]` = 1,0,1,1,0,0,1,0 → `Grant` = 0100 for 10 cycles, `Frame_Done` at cycle 11, `Hit_Count` = 4, `Hit_Owner` = 2.
- All `Req` high continuously → owners 0,1,2,3,0 in successive frames; `Grant` never has more than one bit set; frames spaced 12 cycles apart.
- CNT_W = 2, all-ones stream (8 hits) → `Hit_Count` saturates at 3.
- `Req[1]` dropped at STREAM cycle 3 → frame completes normally, `Frame_Done` still pulses, `Hit_Owner` = 1.
- `Reset` asserted at STREAM cycle 4 → next cycle `Grant` = 0, `Det_Reset_n` = 0, `Hit_Count` = 0, no `Frame_Done`. A subsequent `Req[3]`-only frame yields owner 3.
- `Req` = 1010 with pointer = 1 → `Grant[3]` first, then `Grant[1]`.
